// File: rtl/display_arbiter_pkg.sv
// Shared definitions for the display arbiter: state encoding, digit geometry
// and a nibble-extraction helper.
package display_arbiter_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int NUM_DIGITS = 4;
  localparam int DATA_W     = NIBBLE_W * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_e;

  // Digit idx (0 = rightmost digit 1) of a packed nibble word.
  function automatic logic [NIBBLE_W-1:0] get_digit(input logic [DATA_W-1:0] data,
                                                    input int idx);
    return data[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/arb_slice_counter.sv
// Saturating slice counter with synchronous clear and a terminal-count flag.
// Only instantiated when DISPLAY_ARB_TIMESLICE_EN is defined.
module arb_slice_counter #(
  parameter int MAX_COUNT = 999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_COUNT);

  logic [CW-1:0] cnt;

  // Clear wins over count; counting stops at the terminal value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CMAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CMAX);

endmodule

// File: rtl/display_arbiter.sv
// Two-requester arbiter for a 4-digit 7-segment display.
// Round-robin on simultaneous requests from IDLE; the holder keeps the display
// until it drops its request. Define DISPLAY_ARB_TIMESLICE_EN to also hand the
// display over after SLICE_CYCLES cycles when the other side is waiting.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int SLICE_CYCLES = 1000
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Req_A,
  input  logic                i_Req_B,
  input  logic [DATA_W-1:0]   i_Datos_A,
  input  logic [DATA_W-1:0]   i_Datos_B,
  output logic                o_Gnt_A,
  output logic                o_Gnt_B,
  output logic [NIBBLE_W-1:0] o_Datos1,
  output logic [NIBBLE_W-1:0] o_Datos2,
  output logic [NIBBLE_W-1:0] o_Datos3,
  output logic [NIBBLE_W-1:0] o_Datos4,
  output logic                o_Valido
);

  arb_state_e        state;
  arb_state_e        nxt;
  logic              prio_b;   // 1: B wins the next tie, 0: A wins
  logic [DATA_W-1:0] data_q;
  logic              slice_tc;

`ifdef DISPLAY_ARB_TIMESLICE_EN
  logic slice_clr;
  logic slice_en;

  assign slice_clr = (nxt != state);
  assign slice_en  = (state != IDLE);

  arb_slice_counter #(
    .MAX_COUNT (SLICE_CYCLES - 1)
  ) u_slice (
    .clk (i_Clk),
    .rst (i_Rst),
    .clr (slice_clr),
    .en  (slice_en),
    .tc  (slice_tc)
  );
`else
  logic slice_unused;
  assign slice_unused = (SLICE_CYCLES > 0);
  assign slice_tc     = 1'b0;
`endif

  // Grant decision for the coming edge; also drives the slice counter clear.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (i_Req_A && (!i_Req_B || !prio_b)) nxt = GNT_A;
        else if (i_Req_B)                    nxt = GNT_B;
      end
      GNT_A: begin
        if (!i_Req_A || (slice_tc && i_Req_B)) nxt = i_Req_B ? GNT_B : IDLE;
      end
      GNT_B: begin
        if (!i_Req_B || (slice_tc && i_Req_A)) nxt = i_Req_A ? GNT_A : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State, registered grants and display data; data holds while idle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= IDLE;
      o_Gnt_A  <= 1'b0;
      o_Gnt_B  <= 1'b0;
      o_Valido <= 1'b0;
      data_q   <= '0;
      prio_b   <= 1'b0;
    end else begin
      state    <= nxt;
      o_Gnt_A  <= (nxt == GNT_A);
      o_Gnt_B  <= (nxt == GNT_B);
      o_Valido <= (nxt != IDLE);
      case (nxt)
        GNT_A: begin
          data_q <= i_Datos_A;
          prio_b <= 1'b1;
        end
        GNT_B: begin
          data_q <= i_Datos_B;
          prio_b <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_Datos1 = get_digit(data_q, 0);
  assign o_Datos2 = get_digit(data_q, 1);
  assign o_Datos3 = get_digit(data_q, 2);
  assign o_Datos4 = get_digit(data_q, 3);

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter SLICE_CYCLES, default 1000, maximum cycles a holder keeps the display while the other requester waits (time-slice mode only).
REQ-002 SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-003 SHALL have port i_Clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports i_Req_A / i_Req_B  input  1  display request from requester A / B.
REQ-006 SHALL have ports i_Datos_A / i_Datos_B  input  16  four BCD/hex nibbles from requester A / B, [3:0]=digit 1 ... [15:12]=digit 4.
REQ-007 SHALL have ports o_Gnt_A / o_Gnt_B  output  1  grant to A / B, registered, never both high.
REQ-008 SHALL have ports o_Datos1..o_Datos4  output  4 each  nibbles driven to the 4-digit 7-segment display controller.
REQ-009 SHALL have port o_Valido  output  1  high while any grant is active.

Function
REQ-010 SHALL implement states IDLE, GNT_A, GNT_B; o_Gnt_A=1 only in GNT_A, o_Gnt_B=1 only in GNT_B, o_Valido=1 in GNT_A or GNT_B.
REQ-011 SHALL in IDLE move to GNT_A if only i_Req_A is high, or to GNT_B if only i_Req_B is high, on the next edge.
REQ-012 SHALL on simultaneous requests from IDLE grant the requester not served last (round-robin pointer); the pointer after reset favours A.
REQ-013 SHALL while in GNT_x with i_Req_x high keep the grant, except under REQ-018.
REQ-014 SHALL when the holder deasserts its request, move on the next edge to the other grant if the other request is high, else to IDLE.
REQ-015 SHALL register o_Datos1..4 from the granted source: a one-cycle latency from i_Datos_x to o_DatosN, updated on the same edge the grant asserts.
REQ-016 SHALL in IDLE hold o_Datos1..4 at their last value, so the display shows no glitch.
REQ-017 SHALL keep a slice counter that clears on every grant change, increments each cycle in GNT_x, and saturates at SLICE_CYCLES-1.

Reset
REQ-019 SHALL on i_Rst=1 at an edge force IDLE, o_Gnt_A=o_Gnt_B=0, o_Valido=0, o_Datos1..4=0, slice counter=0 and pointer=A, regardless of requests; reset mid-grant drops the grant at that edge.
REQ-020 SHALL ignore requests during reset; arbitration resumes on the first edge after i_Rst falls.

Configuration
REQ-018 SHALL, with macro DISPLAY_ARB_TIMESLICE_EN defined, move GNT_x to the other grant when the slice counter equals SLICE_CYCLES-1 and the other request is high, even if i_Req_x stays high; without the macro, the counter is absent and a holder keeps the grant until it deasserts its request.

Structure
REQ-021 SHALL take the state enumeration, nibble width (4) and digit count (4) from a shared package display_arbiter_pkg.
REQ-022 SHALL place the slice counter in a sub-module arb_slice_counter (clear, enable, saturate, terminal-count output), instantiated only under DISPLAY_ARB_TIMESLICE_EN.

Verification
REQ-023 SHALL test reset: i_Rst=1 for 2 cycles with both requests high -> all grants 0, o_Datos1..4=0, o_Valido=0.
REQ-024 SHALL test a single request: i_Req_A=1, i_Datos_A=16'hEFAC -> one edge later o_Gnt_A=1, o_Datos1=C, o_Datos2=A, o_Datos3=F, o_Datos4=E.
REQ-025 SHALL test a simultaneous first request: A and B rise together after reset -> GNT_A; A drops -> the next edge gives GNT_B; o_Datos follow i_Datos_B=16'h1234 (o_Datos1=4).
REQ-026 SHALL test the time slice: with the macro and SLICE_CYCLES=4, A and B held high -> grant alternates A,B every 4 cycles; without the macro, A is held indefinitely.
REQ-027 SHALL test idle hold: the holder drops its request with no other request -> IDLE, o_Valido=0, o_Datos1..4 unchanged.
REQ-028 SHALL test reset mid-operation: i_Rst pulses during GNT_B -> the grant drops at that edge; after release with both requests high, A is granted.
